// File: rtl/uart_report_pkg.sv
// Shared types and constants for the UART time reporter: FSM states, ASCII
// framing characters and the BCD-to-ASCII digit mapping.
package uart_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT
  } state_e;

  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] QMARK = 8'h3F;
  localparam logic [7:0] TAG_P = 8'h50;

  localparam int FRAME_LEN_BASE = 7;

  // Non-BCD nibbles are shown as '?' so a corrupted digit is visible on the host.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? QMARK : (8'h30 + {4'h0, d});
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: baud counter plus 10-bit shift register, LSB first,
// idle high. Exposes bit position and counter phase so the caller can track it.
module uart_tx_byte #(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic [3:0] o_bit,
  output logic       o_cnt_last,
  output logic       o_cnt_prelast
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRELAST = CW'(DIV - 2);

  logic          r_active;
  logic          r_tx;
  logic [9:0]    r_shift;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_cnt;

  // Handshake: a byte is taken on any cycle where i_load && o_ready. o_ready is
  // high when idle and also during the final stop-bit cycle, so bytes can run
  // back-to-back with no idle gap between them.
  assign o_cnt_last    = (r_cnt == CNT_LAST);
  assign o_cnt_prelast = (r_cnt == CNT_PRELAST);
  assign o_ready       = !r_active || ((r_bit == 4'd9) && o_cnt_last);
  assign o_tx          = r_tx;
  assign o_bit         = r_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_tx     <= 1'b1;
      r_shift  <= '1;
      r_bit    <= '0;
      r_cnt    <= '0;
    end else if (i_load && o_ready) begin
      r_active <= 1'b1;
      r_tx     <= 1'b0;
      r_shift  <= {1'b1, i_data, 1'b0};
      r_bit    <= '0;
      r_cnt    <= '0;
    end else if (r_active) begin
      if (o_cnt_last) begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_shift <= {1'b1, r_shift[9:1]};
          r_tx    <= r_shift[1];
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_time_reporter.sv
// Streams "MM:SS\r\n" over UART whenever the BCD time changes or on send_req.
// Optional UART_REPORT_PAUSE_TAG_EN inserts 'P' before CR/LF when stopped.
module uart_time_reporter
  import uart_report_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BAUD     = 115_200,
  parameter int Q_DROP_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          min_tens,
  input  logic [3:0]          min_ones,
  input  logic [3:0]          sec_tens,
  input  logic [3:0]          sec_ones,
  input  logic                count_enable,
  input  logic                send_req,
  output logic                tx,
  output logic                busy,
  output logic [Q_DROP_W-1:0] drop_cnt,
  output state_e              dbg_state
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;

  state_e              r_state, w_next;
  logic [15:0]         w_digits, w_src, r_snap, r_prev;
  logic                r_chg, r_upd, r_pending, r_busy;
  logic [Q_DROP_W-1:0] r_drop;
  logic [2:0]          r_idx, w_cidx, w_last_idx;
  logic                w_ce_snap_diff, w_ce_prev_diff, w_tag;
  logic [7:0]          w_char;
  logic                w_load, w_tx_ready, w_cnt_last, w_cnt_prelast, w_in_frame, w_tx;
  logic [3:0]          w_bit;

  assign w_digits = {min_tens, min_ones, sec_tens, sec_ones};

`ifdef UART_REPORT_PAUSE_TAG_EN
  logic r_snap_ce, r_prev_ce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_ce <= 1'b1;
      r_prev_ce <= 1'b1;
    end else begin
      r_prev_ce <= count_enable;
      if (r_state == ST_LOAD) r_snap_ce <= count_enable;
    end
  end

  assign w_ce_snap_diff = (count_enable != r_snap_ce);
  assign w_ce_prev_diff = (count_enable != r_prev_ce);
  assign w_tag          = !r_snap_ce;
`else
  logic w_unused_ce;
  assign w_unused_ce    = count_enable;
  assign w_ce_snap_diff = 1'b0;
  assign w_ce_prev_diff = 1'b0;
  assign w_tag          = 1'b0;
`endif

  assign w_last_idx = w_tag ? 3'd7 : 3'(FRAME_LEN_BASE - 1);
  assign w_in_frame = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_STOP)  || (r_state == ST_NEXT);

  // LOAD sends char 0 on the same edge the snapshot is captured, so it reads live digits.
  always_comb begin
    w_src  = (r_state == ST_LOAD) ? w_digits : r_snap;
    w_cidx = (r_state == ST_NEXT) ? (r_idx + 3'd1) : 3'd0;
    case (w_cidx)
      3'd0:    w_char = bcd_to_ascii(w_src[15:12]);
      3'd1:    w_char = bcd_to_ascii(w_src[11:8]);
      3'd2:    w_char = COLON;
      3'd3:    w_char = bcd_to_ascii(w_src[7:4]);
      3'd4:    w_char = bcd_to_ascii(w_src[3:0]);
      3'd5:    w_char = w_tag ? TAG_P : CR;
      3'd6:    w_char = w_tag ? CR : LF;
      default: w_char = LF;
    endcase
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE:  if (r_chg) w_next = ST_LOAD;
      ST_LOAD: begin
        w_load = 1'b1;
        w_next = ST_START;
      end
      ST_START: if (w_bit == 4'd0 && w_cnt_last) w_next = ST_DATA;
      ST_DATA:  if (w_bit == 4'd8 && w_cnt_last) w_next = ST_STOP;
      // NEXT overlaps the final stop-bit cycle so the next start bit follows without a gap.
      ST_STOP:  if (w_bit == 4'd9 && w_cnt_prelast) w_next = ST_NEXT;
      ST_NEXT: begin
        if (r_idx < w_last_idx) begin
          w_load = 1'b1;
          w_next = ST_START;
        end else if (r_pending || r_upd) begin
          w_next = ST_LOAD;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_snap    <= 16'hFFFF;
      r_prev    <= 16'hFFFF;
      r_chg     <= 1'b0;
      r_upd     <= 1'b0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
      r_drop    <= '0;
      r_idx     <= '0;
    end else begin
      r_state <= w_next;
      r_prev  <= w_digits;
      // r_chg is a level compare for IDLE; r_upd flags each new event while a frame runs.
      r_chg   <= (w_digits != r_snap) || w_ce_snap_diff || send_req;
      r_upd   <= (r_state != ST_LOAD) &&
                 ((w_digits != r_prev) || w_ce_prev_diff || send_req);
      if (r_state == ST_LOAD) begin
        r_snap    <= w_digits;
        r_pending <= 1'b0;
        r_idx     <= '0;
        r_busy    <= 1'b1;
      end else if (w_in_frame && r_upd) begin
        if (!r_pending) r_pending <= 1'b1;
        else if (r_drop != '1) r_drop <= r_drop + 1'b1;
      end
      if (r_state == ST_NEXT) begin
        if (r_idx < w_last_idx) r_idx <= r_idx + 3'd1;
        else r_busy <= 1'b0;
      end
    end
  end

  uart_tx_byte #(
    .DIV (BAUD_DIV)
  ) u_tx (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_load        (w_load),
    .i_data        (w_char),
    .o_ready       (w_tx_ready),
    .o_tx          (w_tx),
    .o_bit         (w_bit),
    .o_cnt_last    (w_cnt_last),
    .o_cnt_prelast (w_cnt_prelast)
  );

  logic w_unused_ready;
  assign w_unused_ready = w_tx_ready;

  assign tx        = w_tx;
  assign busy      = r_busy;
  assign drop_cnt  = r_drop;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_time_reporter.sv
// Bench for uart_time_reporter: UART decoder monitor checks bytes against a
// frame-level reference model; the driver issues directed and random scenarios.
module tb_uart_time_reporter;
  import uart_report_pkg::*;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mt, mo, st, so;
  logic       ce, send_req;
  logic       tx, busy;
  logic [7:0] drop_cnt;
  state_e     dbg_state;

  always #5 clk = ~clk;

  uart_time_reporter #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .Q_DROP_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .min_tens     (mt),
    .min_ones     (mo),
    .sec_tens     (st),
    .sec_ones     (so),
    .count_enable (ce),
    .send_req     (send_req),
    .tx           (tx),
    .busy         (busy),
    .drop_cnt     (drop_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  int         exp_drop = 0;
  bit         tag_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'd48 + {4'd0, d}) : 8'd63;
  endfunction

  function automatic bit tag_on(input logic cen);
    bit en = 1'b0;
`ifdef UART_REPORT_PAUSE_TAG_EN
    en = 1'b1;
`endif
    return en && !cen;
  endfunction

  task automatic push_frame(input logic [15:0] d, input bit tag);
    exp_q.push_back(digit_char(d[15:12]));
    exp_q.push_back(digit_char(d[11:8]));
    exp_q.push_back(8'h3A);
    exp_q.push_back(digit_char(d[7:4]));
    exp_q.push_back(digit_char(d[3:0]));
    if (tag) exp_q.push_back(8'h50);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // ---------------- monitor: 8N1 decoder sampling mid-bit on negedges ----------------
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [9:0] mon_bits = '0;
  logic       prev_tx = 1'b1;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!mon_act) begin
        if (prev_tx === 1'b1 && tx === 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % DIV == DIV / 2 - 1) begin
          mon_bits[mon_cnt / DIV] = tx;
          if (mon_cnt / DIV == 9) begin
            mon_act = 1'b0;
            chk("start_stop_bits", 32'({mon_bits[9], mon_bits[0]}), 32'(2'b10));
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_byte: got %02h expected no byte at %0t",
                       mon_bits[8:1], $time);
            end else begin
              mon_exp = exp_q.pop_front();
              chk("byte", 32'(mon_bits[8:1]), 32'(mon_exp));
            end
          end
        end
      end
      prev_tx = tx;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [15:0] cur();
    return {mt, mo, st, so};
  endfunction

  function automatic logic [3:0] rnd_nib();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  function automatic logic [15:0] rand_diff(input logic [15:0] old);
    logic [15:0] d;
    do d = {rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib()}; while (d == old);
    return d;
  endfunction

  task automatic set_in(input logic [15:0] d);
    @(negedge clk);
    {mt, mo, st, so} = d;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    send_req = 1'b1;
    @(negedge clk);
    send_req = 1'b0;
  endtask

  task automatic wait_busy(input string name);
    int i = 0;
    while (i < 20 && busy !== 1'b1) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(busy), 32'(1));
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    int quiet = 0;
    while (i < 4000 && !(quiet >= 10 && exp_q.size() == 0)) begin
      @(negedge clk);
      i++;
      quiet = (busy === 1'b0) ? quiet + 1 : 0;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'(0));
    chk({name, "_idle"}, 32'(quiet >= 10), 32'(1));
  endtask

  // Events during a running frame: the first queues a frame, each later one is coalesced.
  task automatic burst(input int n);
    repeat (5) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_req();
      else set_in(rand_diff(cur()));
      repeat ($urandom_range(2, 12)) @(negedge clk);
    end
    if (n > 0) begin
      push_frame(cur(), tag_on(ce));
      exp_drop = exp_drop + n - 1;
      if (exp_drop > 255) exp_drop = 255;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  len;
    bit  saw_busy;
`ifdef UART_REPORT_PAUSE_TAG_EN
    tag_en = 1'b1;
`endif
    {mt, mo, st, so} = 16'h0000;
    ce = 1'b1;
    send_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_drop", 32'(drop_cnt), 32'(0));
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));

    // First frame after reset: start bit on the third edge, busy for 7 chars x 10 bits x DIV.
    push_frame(16'h0000, tag_on(ce));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("tx_idle_edge1", 32'(tx), 32'(1));
    @(posedge clk); #1;
    chk("tx_start_edge2", 32'(tx), 32'(0));
    chk("busy_edge2", 32'(busy), 32'(1));
    len = 1;
    while (busy === 1'b1 && len < 2000) begin
      @(posedge clk); #1;
      if (busy === 1'b1) len++;
    end
    chk("busy_len", 32'(len), 32'(70 * DIV));
    wait_idle("first_frame");

    // Single change from idle, then silence while inputs are static.
    set_in(16'h1234);
    push_frame(16'h1234, tag_on(ce));
    wait_idle("frame_1234");
    set_in(16'h1235);
    push_frame(16'h1235, tag_on(ce));
    wait_idle("frame_1235");
    saw_busy = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (busy === 1'b1) saw_busy = 1'b1;
    end
    chk("static_quiet", 32'(saw_busy), 32'(0));

    // Three changes during a frame: one queued frame with the latest digits, two drops.
    pulse_req();
    push_frame(16'h1235, tag_on(ce));
    wait_busy("overlap_busy");
    repeat (20) @(negedge clk);
    set_in(16'h1236);
    repeat (30) @(negedge clk);
    set_in(16'h1237);
    repeat (30) @(negedge clk);
    set_in(16'h1238);
    push_frame(16'h1238, tag_on(ce));
    exp_drop += 2;
    wait_idle("overlap");
    chk("drop_after_overlap", 32'(drop_cnt), 32'(exp_drop));

    // send_req with unchanged digits, and one repeat requested mid-frame.
    set_in(16'h0709);
    push_frame(16'h0709, tag_on(ce));
    wait_idle("frame_0709");
    pulse_req();
    push_frame(16'h0709, tag_on(ce));
    wait_busy("req_busy");
    repeat (100) @(negedge clk);
    pulse_req();
    push_frame(16'h0709, tag_on(ce));
    wait_idle("req_repeat");
    chk("drop_after_req", 32'(drop_cnt), 32'(exp_drop));

    // Non-BCD digit is sent as '?'.
    set_in(16'h123B);
    push_frame(16'h123B, tag_on(ce));
    wait_idle("frame_qmark");

    // Reset during the first data bit of char 0 ('0' has LSB 0).
    set_in(16'h0042);
    push_frame(16'h0042, tag_on(ce));
    wait_busy("rst_busy");
    repeat (14) @(negedge clk);
    chk("pre_reset_data_bit", 32'(tx), 32'(0));
    #1 rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx", 32'(tx), 32'(1));
    chk("midframe_rst_busy", 32'(busy), 32'(0));
    chk("midframe_rst_drop", 32'(drop_cnt), 32'(0));
    exp_q.delete();
    exp_drop = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'h0042, tag_on(ce));
    wait_idle("after_reset");

    // count_enable: a change on its own only matters with the pause tag enabled.
    @(negedge clk);
    ce = 1'b0;
    if (tag_en) push_frame(cur(), tag_on(ce));
    wait_idle("ce_low");
    set_in(16'h0300);
    push_frame(16'h0300, tag_on(ce));
    wait_idle("frame_0300");
    @(negedge clk);
    ce = 1'b1;
    if (tag_en) push_frame(cur(), tag_on(ce));
    wait_idle("ce_high");

    // Random frames with random coalesced events.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 2) == 0) pulse_req();
      else set_in(rand_diff(cur()));
      push_frame(cur(), tag_on(ce));
      wait_busy("rnd_busy");
      burst($urandom_range(0, 4));
      wait_idle("rnd_frame");
      chk("rnd_drop", 32'(drop_cnt), 32'(exp_drop));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
